// File: rtl/hazard_unit_fwd_if.sv
// -----------------------------------------------------------------------------
// hazard_unit_fwd_if
//   Bundle between the pipeline stages and the hazard/forwarding unit.
//   The pipeline side (master) drives the ID-stage operand information, the
//   EX branch resolution and the memory handshake status. The hazard unit
//   (slave) returns the forwarding selects, the per-stage stall/nop controls,
//   the performance counters and the watchdog flag.
//
//   Parameters: RA_W  register address width
//               DEPTH scoreboard entries (sets the fwd_sel width)
//               CNT_W performance counter width
// -----------------------------------------------------------------------------
interface hazard_unit_fwd_if #(
  parameter int RA_W  = 5,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
);
  localparam int SW = $clog2(DEPTH + 1);

  // ID stage instruction
  logic            id_valid;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic            id_regwrite;
  logic [RA_W-1:0] id_waddr;
  logic            id_is_load;

  // EX branch resolution and memory status
  logic            branch_PC_contral;
  logic            iready_n;
  logic            dready_n;
  logic            dbusy;
  logic [1:0]      MemRW_pype2;

  // Controls returned to the pipeline
  logic [SW-1:0]   fwd_sel_rs1;
  logic [SW-1:0]   fwd_sel_rs2;
  logic            stall_IF;
  logic            stall_ID;
  logic            stall_EX;
  logic            stall_Mem;
  logic            stall_WB;
  logic            nop_ID;
  logic            nop_EX;
  logic [CNT_W-1:0] perf_hazard;
  logic [CNT_W-1:0] perf_flush;
  logic [CNT_W-1:0] perf_memstall;
  logic            mem_timeout;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_regwrite, id_waddr, id_is_load,
           branch_PC_contral, iready_n, dready_n, dbusy, MemRW_pype2,
    input  fwd_sel_rs1, fwd_sel_rs2,
           stall_IF, stall_ID, stall_EX, stall_Mem, stall_WB,
           nop_ID, nop_EX,
           perf_hazard, perf_flush, perf_memstall, mem_timeout
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_regwrite, id_waddr, id_is_load,
           branch_PC_contral, iready_n, dready_n, dbusy, MemRW_pype2,
    output fwd_sel_rs1, fwd_sel_rs2,
           stall_IF, stall_ID, stall_EX, stall_Mem, stall_WB,
           nop_ID, nop_EX,
           perf_hazard, perf_flush, perf_memstall, mem_timeout
  );
endinterface

// File: rtl/hazard_unit_fwd.sv
// -----------------------------------------------------------------------------
// hazard_unit_fwd
//   Pipeline hazard controller with a scoreboard of in-flight register
//   writers (entry 0 = EX, 1 = MEM, 2 = WB, ...). Produces forwarding selects
//   for both ID operands, load-use / no-forward stalls, branch flush and the
//   memory-access freeze, plus saturating performance counters and a
//   memory-stall watchdog.
//
//   Ports: clk  clock
//          rst  synchronous reset, active low
//          bus  hazard_unit_fwd_if.slave (ID operands, branch, memory status
//               in; fwd selects, stall_*/nop_*, counters, mem_timeout out)
//
//   fwd_sel encoding: 0 = register file, k = scoreboard entry k-1.
// -----------------------------------------------------------------------------
module hazard_unit_fwd #(
  parameter int RA_W     = 5,
  parameter int DEPTH    = 3,
  parameter int FWD_EN   = 1,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 255
) (
  input logic              clk,
  input logic              rst,
  hazard_unit_fwd_if.slave bus
);
  localparam int SW   = $clog2(DEPTH + 1);
  // One spare value so the counter can sit at TIMEOUT without wrapping.
  localparam int WD_W = $clog2(TIMEOUT + 2);

  // Scoreboard
  logic [DEPTH-1:0] sb_valid_reg, sb_valid_next;
  logic [DEPTH-1:0] sb_load_reg,  sb_load_next;
  logic [RA_W-1:0]  sb_waddr_reg  [DEPTH];
  logic [RA_W-1:0]  sb_waddr_next [DEPTH];

  logic [CNT_W-1:0] perf_hazard_reg, perf_flush_reg, perf_memstall_reg;
  logic [WD_W-1:0]  wd_cnt_reg;
  logic             mem_timeout_reg;

  logic             mem_stall;
  logic             hazard;
  logic [DEPTH-1:0] match_rs1, match_rs2;
  logic [SW-1:0]    win_rs1, win_rs2;
  logic             win_rs1_load, win_rs2_load;
  logic             lu_rs1, lu_rs2;
  logic [SW-1:0]    fwd_rs1, fwd_rs2;

  assign mem_stall = bus.iready_n
                   | (bus.dready_n & bus.MemRW_pype2[1])
                   | (bus.dbusy    & bus.MemRW_pype2[0]);

  // Per-entry operand compare. x0 and unused operands never match.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match_rs1[gi] = sb_valid_reg[gi] && (sb_waddr_reg[gi] == bus.id_rs1)
                          && bus.id_rs1_used && (bus.id_rs1 != '0);
      assign match_rs2[gi] = sb_valid_reg[gi] && (sb_waddr_reg[gi] == bus.id_rs2)
                          && bus.id_rs2_used && (bus.id_rs2 != '0);
    end
  endgenerate

  // Youngest match wins: scan oldest to youngest so lower indices overwrite.
  always_comb begin
    win_rs1      = '0;
    win_rs2      = '0;
    win_rs1_load = 1'b0;
    win_rs2_load = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_rs1[i]) begin
        win_rs1      = SW'(i + 1);
        win_rs1_load = sb_load_reg[i];
      end
      if (match_rs2[i]) begin
        win_rs2      = SW'(i + 1);
        win_rs2_load = sb_load_reg[i];
      end
    end
  end

  // A load is not yet forwardable while it sits at entry index < LOAD_LAT,
  // i.e. while its select value (index+1) is <= LOAD_LAT.
  assign lu_rs1 = (win_rs1 != '0) && win_rs1_load && (int'(win_rs1) <= LOAD_LAT);
  assign lu_rs2 = (win_rs2 != '0) && win_rs2_load && (int'(win_rs2) <= LOAD_LAT);

  always_comb begin
    hazard  = 1'b0;
    fwd_rs1 = '0;
    fwd_rs2 = '0;
    if (FWD_EN != 0) begin
      hazard  = bus.id_valid & (lu_rs1 | lu_rs2);
      fwd_rs1 = win_rs1;
      fwd_rs2 = win_rs2;
    end else begin
      // Without forwarding every in-flight producer must retire first.
      hazard  = bus.id_valid & ((|match_rs1) | (|match_rs2));
    end
  end

  // Scoreboard next state: freeze on mem_stall, otherwise shift toward WB.
  // Entry 0 takes a bubble on branch flush or hazard, else the ID writer.
  always_comb begin
    sb_valid_next = sb_valid_reg;
    sb_load_next  = sb_load_reg;
    sb_waddr_next = sb_waddr_reg;
    if (!mem_stall) begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        sb_valid_next[i] = sb_valid_reg[i-1];
        sb_load_next[i]  = sb_load_reg[i-1];
        sb_waddr_next[i] = sb_waddr_reg[i-1];
      end
      if (bus.branch_PC_contral || hazard) begin
        sb_valid_next[0] = 1'b0;
        sb_load_next[0]  = 1'b0;
        sb_waddr_next[0] = '0;
      end else begin
        sb_valid_next[0] = bus.id_valid & bus.id_regwrite & (bus.id_waddr != '0);
        sb_load_next[0]  = bus.id_is_load;
        sb_waddr_next[0] = bus.id_waddr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sb_valid_reg      <= '0;
      sb_load_reg       <= '0;
      for (int i = 0; i < DEPTH; i++) sb_waddr_reg[i] <= '0;
      perf_hazard_reg   <= '0;
      perf_flush_reg    <= '0;
      perf_memstall_reg <= '0;
      wd_cnt_reg        <= '0;
      mem_timeout_reg   <= 1'b0;
    end else begin
      sb_valid_reg <= sb_valid_next;
      sb_load_reg  <= sb_load_next;
      sb_waddr_reg <= sb_waddr_next;

      // A hazard coincident with a branch belongs to a flushed instruction.
      if (hazard && !bus.branch_PC_contral && !mem_stall && (perf_hazard_reg != '1))
        perf_hazard_reg <= perf_hazard_reg + CNT_W'(1);
      if (bus.nop_ID && (perf_flush_reg != '1))
        perf_flush_reg <= perf_flush_reg + CNT_W'(1);
      if (mem_stall && (perf_memstall_reg != '1))
        perf_memstall_reg <= perf_memstall_reg + CNT_W'(1);

      if (mem_stall) begin
        if (wd_cnt_reg != WD_W'(TIMEOUT))
          wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
        // Flag rises on the edge where the run length reaches TIMEOUT.
        if (wd_cnt_reg >= WD_W'(TIMEOUT - 1))
          mem_timeout_reg <= 1'b1;
      end else begin
        wd_cnt_reg <= '0;
      end
    end
  end

  assign bus.fwd_sel_rs1   = fwd_rs1;
  assign bus.fwd_sel_rs2   = fwd_rs2;
  assign bus.stall_IF      = mem_stall | (hazard & ~bus.branch_PC_contral);
  assign bus.stall_ID      = mem_stall | (hazard & ~bus.branch_PC_contral);
  assign bus.stall_EX      = mem_stall;
  assign bus.stall_Mem     = mem_stall;
  assign bus.stall_WB      = mem_stall;
  assign bus.nop_ID        = bus.branch_PC_contral & ~mem_stall;
  assign bus.nop_EX        = (bus.branch_PC_contral | hazard) & ~mem_stall;
  assign bus.perf_hazard   = perf_hazard_reg;
  assign bus.perf_flush    = perf_flush_reg;
  assign bus.perf_memstall = perf_memstall_reg;
  assign bus.mem_timeout   = mem_timeout_reg;
endmodule

// File: tb/tb_hazard_unit_fwd.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit_fwd
//   Two instances share one stimulus: dut_a forwards (LOAD_LAT=1), dut_b does
//   not (FWD_EN=0). Both use DEPTH=3 and TIMEOUT=16. A directed vector table
//   walks dut_a through forwarding, load-use and memory stalls; hand-written
//   sequences cover the no-forward stall length, branch-vs-hazard priority,
//   the watchdog and reset.
// -----------------------------------------------------------------------------
module tb_hazard_unit_fwd;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_unit_fwd_if #(.RA_W(5), .DEPTH(3), .CNT_W(16)) ifa ();
  hazard_unit_fwd_if #(.RA_W(5), .DEPTH(3), .CNT_W(16)) ifb ();

  hazard_unit_fwd #(.RA_W(5), .DEPTH(3), .FWD_EN(1), .LOAD_LAT(1), .CNT_W(16), .TIMEOUT(16))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  hazard_unit_fwd #(.RA_W(5), .DEPTH(3), .FWD_EN(0), .LOAD_LAT(1), .CNT_W(16), .TIMEOUT(16))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Shared stimulus
  logic       s_v, s_u1, s_u2, s_rw, s_ld, s_br, s_ir, s_dr, s_db;
  logic [4:0] s_rs1, s_rs2, s_wa;
  logic [1:0] s_mrw;

  assign ifa.id_valid = s_v;     assign ifb.id_valid = s_v;
  assign ifa.id_rs1 = s_rs1;     assign ifb.id_rs1 = s_rs1;
  assign ifa.id_rs2 = s_rs2;     assign ifb.id_rs2 = s_rs2;
  assign ifa.id_rs1_used = s_u1; assign ifb.id_rs1_used = s_u1;
  assign ifa.id_rs2_used = s_u2; assign ifb.id_rs2_used = s_u2;
  assign ifa.id_regwrite = s_rw; assign ifb.id_regwrite = s_rw;
  assign ifa.id_waddr = s_wa;    assign ifb.id_waddr = s_wa;
  assign ifa.id_is_load = s_ld;  assign ifb.id_is_load = s_ld;
  assign ifa.branch_PC_contral = s_br; assign ifb.branch_PC_contral = s_br;
  assign ifa.iready_n = s_ir;    assign ifb.iready_n = s_ir;
  assign ifa.dready_n = s_dr;    assign ifb.dready_n = s_dr;
  assign ifa.dbusy = s_db;       assign ifb.dbusy = s_db;
  assign ifa.MemRW_pype2 = s_mrw; assign ifb.MemRW_pype2 = s_mrw;

  typedef struct {
    string      nm;
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       rw;
    logic [4:0] wa;
    logic       ld;
    logic       br;
    logic       ir, dr, db;
    logic [1:0] mrw;
    logic [1:0] f1, f2;      // expected fwd selects
    logic       sid, sex;    // expected stall_IF/ID and stall_EX/Mem/WB
    logic       nid, nex;    // expected nop_ID, nop_EX
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input string nm,
                              input int v, input int rs1, input int u1, input int rs2, input int u2,
                              input int rw, input int wa, input int ld, input int br,
                              input int ir, input int dr, input int db, input int mrw,
                              input int f1, input int f2, input int sid, input int sex,
                              input int nid, input int nex);
    vec_t r;
    r.nm = nm;    r.v = 1'(v);     r.rs1 = 5'(rs1); r.u1 = 1'(u1);
    r.rs2 = 5'(rs2); r.u2 = 1'(u2); r.rw = 1'(rw);   r.wa = 5'(wa);
    r.ld = 1'(ld); r.br = 1'(br);  r.ir = 1'(ir);   r.dr = 1'(dr);
    r.db = 1'(db); r.mrw = 2'(mrw); r.f1 = 2'(f1);  r.f2 = 2'(f2);
    r.sid = 1'(sid); r.sex = 1'(sex); r.nid = 1'(nid); r.nex = 1'(nex);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    s_v = t.v; s_rs1 = t.rs1; s_u1 = t.u1; s_rs2 = t.rs2; s_u2 = t.u2;
    s_rw = t.rw; s_wa = t.wa; s_ld = t.ld; s_br = t.br;
    s_ir = t.ir; s_dr = t.dr; s_db = t.db; s_mrw = t.mrw;
  endtask

  // Instruction in ID: valid, reads rs1 (if nonzero) and writes wa (if nonzero).
  task automatic id_instr(input int rs1, input int rs2, input int wa, input int ld, input int br, input int ir);
    drive(mk("", 1, rs1, (rs1 != 0) ? 1 : 0, rs2, (rs2 != 0) ? 1 : 0,
             (wa != 0) ? 1 : 0, wa, ld, br, ir, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic idle();
    drive(mk("", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    int stall_cnt;

    //        name          v rs1 u1 rs2 u2 rw wa ld br ir dr db mrw  f1 f2 sid sex nid nex
    tbl[0]  = mk("add_x5",      1, 1, 1, 2, 1, 1, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[1]  = mk("fwd_ex",      1, 5, 1, 5, 1, 1, 6, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    tbl[2]  = mk("fwd_mem_ex",  1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0);
    tbl[3]  = mk("fwd_wb_mem",  1, 5, 1, 6, 1, 1, 3, 0, 0, 0, 0, 0, 0,  3, 2, 0, 0, 0, 0);
    tbl[4]  = mk("wr_x3_again", 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[5]  = mk("youngest_x3", 1, 3, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    tbl[6]  = mk("read_x0",     1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[7]  = mk("lw_x5",       1, 3, 1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0);
    tbl[8]  = mk("load_use",    1, 5, 1, 0, 1, 1, 6, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1);
    tbl[9]  = mk("load_fwd",    1, 5, 1, 0, 1, 1, 6, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0);
    tbl[10] = mk("istall",      1, 6, 1, 0, 0, 1, 7, 0, 0, 1, 0, 0, 0,  1, 0, 1, 1, 0, 0);
    tbl[11] = mk("istall_end",  1, 6, 1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    tbl[12] = mk("dready_wr",   1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  1, 0, 0, 0, 0, 0);
    tbl[13] = mk("dbusy_wr",    1, 7, 1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 1,  2, 3, 1, 1, 0, 0);
    tbl[14] = mk("dready_rd",   1, 7, 1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 2,  2, 3, 1, 1, 0, 0);
    tbl[15] = mk("branch",      1, 7, 1, 6, 1, 1, 8, 0, 1, 0, 0, 0, 0,  2, 3, 0, 0, 1, 1);

    idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_perf_hazard", 32'(ifa.perf_hazard), 0);
    chk("reset_mem_timeout", 32'(ifa.mem_timeout), 0);

    // ---------------- vector table on dut_a ----------------
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      $display("vec %0d %s: fwd1=%0d fwd2=%0d stall_ID=%0b stall_EX=%0b nop_ID=%0b nop_EX=%0b",
               i, tbl[i].nm, ifa.fwd_sel_rs1, ifa.fwd_sel_rs2, ifa.stall_ID, ifa.stall_EX,
               ifa.nop_ID, ifa.nop_EX);
      chk({tbl[i].nm, ".fwd1"},     32'(ifa.fwd_sel_rs1), 32'(tbl[i].f1));
      chk({tbl[i].nm, ".fwd2"},     32'(ifa.fwd_sel_rs2), 32'(tbl[i].f2));
      chk({tbl[i].nm, ".stall_IF"}, 32'(ifa.stall_IF),    32'(tbl[i].sid));
      chk({tbl[i].nm, ".stall_ID"}, 32'(ifa.stall_ID),    32'(tbl[i].sid));
      chk({tbl[i].nm, ".stall_EX"}, 32'(ifa.stall_EX),    32'(tbl[i].sex));
      chk({tbl[i].nm, ".stall_WB"}, 32'(ifa.stall_WB),    32'(tbl[i].sex));
      chk({tbl[i].nm, ".nop_ID"},   32'(ifa.nop_ID),      32'(tbl[i].nid));
      chk({tbl[i].nm, ".nop_EX"},   32'(ifa.nop_EX),      32'(tbl[i].nex));
    end
    @(negedge clk);
    idle();
    #1;
    $display("table counters: hazard=%0d flush=%0d memstall=%0d",
             ifa.perf_hazard, ifa.perf_flush, ifa.perf_memstall);
    chk("table.perf_hazard",   32'(ifa.perf_hazard),   1);
    chk("table.perf_flush",    32'(ifa.perf_flush),    1);
    chk("table.perf_memstall", 32'(ifa.perf_memstall), 3);

    // ---------------- reset mid-state, then empty scoreboard ----------------
    do_reset();
    chk("rst.perf_hazard",   32'(ifa.perf_hazard),   0);
    chk("rst.perf_flush",    32'(ifa.perf_flush),    0);
    chk("rst.perf_memstall", 32'(ifa.perf_memstall), 0);
    id_instr(8, 6, 0, 0, 0, 0);  // x8/x6 were in flight before reset
    #1;
    $display("after reset read x8,x6: fwd1=%0d fwd2=%0d stall_ID=%0b",
             ifa.fwd_sel_rs1, ifa.fwd_sel_rs2, ifa.stall_ID);
    chk("rst.fwd1",     32'(ifa.fwd_sel_rs1), 0);
    chk("rst.fwd2",     32'(ifa.fwd_sel_rs2), 0);
    chk("rst.stall_ID", 32'(ifa.stall_ID),    0);

    // ---------------- no forwarding: stall exactly DEPTH cycles ----------------
    do_reset();
    id_instr(0, 0, 5, 0, 0, 0);
    stall_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      id_instr(5, 5, 6, 0, 0, 0);
      #1;
      $display("nofwd cycle %0d: b.stall_ID=%0b b.fwd1=%0d a.fwd1=%0d a.stall_ID=%0b",
               k, ifb.stall_ID, ifb.fwd_sel_rs1, ifa.fwd_sel_rs1, ifa.stall_ID);
      if (ifb.stall_ID) stall_cnt++;
      chk("nofwd.stall_ID", 32'(ifb.stall_ID), (k < 3) ? 1 : 0);
      chk("nofwd.fwd1",     32'(ifb.fwd_sel_rs1), 0);
      chk("nofwd.fwd2",     32'(ifb.fwd_sel_rs2), 0);
      if (k == 0) begin
        chk("fwd.fwd1",        32'(ifa.fwd_sel_rs1), 1);
        chk("fwd.stall_ID",    32'(ifa.stall_ID),    0);
        chk("fwd.perf_hazard", 32'(ifa.perf_hazard), 0);
      end
      // Once released the reader itself enters EX; stop before it is re-read.
      if (k == 3) begin
        @(negedge clk);
        idle();
        break;
      end
    end
    chk("nofwd.stall_cycles", 32'(stall_cnt), 3);

    // ---------------- branch coincident with load-use ----------------
    do_reset();
    id_instr(0, 0, 5, 1, 0, 0);          // lw x5
    @(negedge clk);
    id_instr(5, 0, 6, 0, 1, 0);          // add x6,x5 while branch taken
    #1;
    $display("branch+load_use: nop_ID=%0b nop_EX=%0b stall_ID=%0b",
             ifa.nop_ID, ifa.nop_EX, ifa.stall_ID);
    chk("brlu.nop_ID",   32'(ifa.nop_ID),   1);
    chk("brlu.nop_EX",   32'(ifa.nop_EX),   1);
    chk("brlu.stall_ID", 32'(ifa.stall_ID), 0);
    @(negedge clk);
    idle();
    #1;
    $display("branch+load_use counters: flush=%0d hazard=%0d", ifa.perf_flush, ifa.perf_hazard);
    chk("brlu.perf_flush",  32'(ifa.perf_flush),  1);
    chk("brlu.perf_hazard", 32'(ifa.perf_hazard), 0);

    // ---------------- watchdog: 20 instruction-fetch stall cycles ----------------
    do_reset();
    id_instr(0, 0, 9, 0, 0, 0);          // x9 into EX
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      id_instr(9, 0, 10, 0, 0, 1);
      #1;
      $display("memstall cycle %0d: stalls=%05b nops=%02b fwd1=%0d mem_timeout=%0b",
               k, {ifa.stall_IF, ifa.stall_ID, ifa.stall_EX, ifa.stall_Mem, ifa.stall_WB},
               {ifa.nop_ID, ifa.nop_EX}, ifa.fwd_sel_rs1, ifa.mem_timeout);
      chk("wd.stalls", 32'({ifa.stall_IF, ifa.stall_ID, ifa.stall_EX, ifa.stall_Mem, ifa.stall_WB}), 32'h1f);
      chk("wd.nops",   32'({ifa.nop_ID, ifa.nop_EX}), 0);
      chk("wd.fwd1",   32'(ifa.fwd_sel_rs1), 1);
      chk("wd.mem_timeout", 32'(ifa.mem_timeout), (k >= 16) ? 1 : 0);
    end
    @(negedge clk);
    id_instr(9, 0, 0, 0, 0, 0);
    #1;
    $display("memstall released: mem_timeout=%0b memstall=%0d fwd1=%0d stall_ID=%0b",
             ifa.mem_timeout, ifa.perf_memstall, ifa.fwd_sel_rs1, ifa.stall_ID);
    chk("wd.timeout_sticky", 32'(ifa.mem_timeout),   1);
    chk("wd.perf_memstall",  32'(ifa.perf_memstall), 20);
    chk("wd.frozen_fwd1",    32'(ifa.fwd_sel_rs1),   1);
    chk("wd.stall_ID_off",   32'(ifa.stall_ID),      0);
    do_reset();
    $display("after reset: mem_timeout=%0b memstall=%0d", ifa.mem_timeout, ifa.perf_memstall);
    chk("wd.rst_timeout",  32'(ifa.mem_timeout),   0);
    chk("wd.rst_memstall", 32'(ifa.perf_memstall), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_unit_fwd.md
Name: hazard_unit_fwd

Overview:
- Parametrised successor to the pipeline stall/nop controller.
- Keeps an internal scoreboard of in-flight register writers, one entry per stage downstream of ID.
- Generates forwarding selects for both ID source operands, load-use and no-forward stalls, branch flush, and the memory-access freeze.
- Adds saturating performance counters and a memory-stall watchdog.
- Sits beside the fetch/decode/execute/mem_access stages and drives their stall_*/nop_* inputs.

Parameters:
- RA_W, 5: register address width.
- DEPTH, 3: scoreboard entries. Entry 0 = EX, 1 = MEM, 2 = WB; legal range 1..7.
- FWD_EN, 1: 1 = forwarding enabled; 0 = stall on any scoreboard match.
- LOAD_LAT, 1: a load's result is forwardable only from entry index >= LOAD_LAT.
- CNT_W, 16: performance counter width.
- TIMEOUT, 255: consecutive mem-stall cycles before the watchdog flag sets.

Ports:
- clk, in, 1: clock. Single clock domain.
- rst, in, 1: reset. Synchronous, active-low.
- id_valid, in, 1: ID holds a real instruction.
- id_rs1, id_rs2, in, RA_W: ID source register addresses.
- id_rs1_used, id_rs2_used, in, 1: source is actually read.
- id_regwrite, in, 1: ID instruction writes a register.
- id_waddr, in, RA_W: ID destination register.
- id_is_load, in, 1: ID instruction is a load.
- branch_PC_contral, in, 1: branch/jump taken, resolved in EX.
- iready_n, dready_n, dbusy, in, 1: memory handshake status.
- MemRW_pype2, in, 2: MEM-stage access; [1] = read, [0] = write.
- fwd_sel_rs1, fwd_sel_rs2, out, SW = clog2(DEPTH+1): 0 = register file, k = entry k-1.
- stall_IF, stall_ID, stall_EX, stall_Mem, stall_WB, out, 1: hold the pipeline register feeding that stage.
- nop_ID, nop_EX, out, 1: clear the IF/ID or ID/EX pipeline register.
- perf_hazard, perf_flush, perf_memstall, out, CNT_W: saturating counters.
- mem_timeout, out, 1: sticky watchdog flag.

Behaviour:
- Scoreboard entry fields: {valid, waddr, is_load}.
- mem_stall = iready_n | (dready_n & MemRW_pype2[1]) | (dbusy & MemRW_pype2[0]).
- Operand match: entry valid, entry waddr == operand address, operand used, address != 0.
  - Youngest match (lowest index) wins.
  - No match gives fwd_sel = 0.
- hazard, FWD_EN=1: the winning match for either operand is a load at index < LOAD_LAT.
  - fwd_sel is still driven with the winning index.
- hazard, FWD_EN=0: any match in any entry.
  - fwd_sel is forced to 0.
- hazard is qualified by id_valid.
- Combinational outputs (no registered latency):
  - stall_IF = stall_ID = mem_stall | (hazard & ~branch_PC_contral).
  - stall_EX = stall_Mem = stall_WB = mem_stall.
  - nop_ID = branch_PC_contral & ~mem_stall.
  - nop_EX = (branch_PC_contral | hazard) & ~mem_stall.
- Scoreboard update each clk, in priority order:
  1. rst low: all entries invalid, all counters 0, mem_timeout 0, watchdog counter 0.
  2. mem_stall: hold all entries.
  3. branch_PC_contral: shift entries up (entry DEPTH-1 drops). Entry 0 becomes a bubble. The branch's own entry continues (link write preserved).
  4. hazard: shift; entry 0 becomes a bubble.
  5. Otherwise: shift; entry 0 = {id_valid & id_regwrite & (id_waddr != 0), id_waddr, id_is_load}.
- Branch has priority over hazard. The younger, hazarding instruction is flushed, so no hazard cycle is counted.
- Counters saturate at all-ones and never wrap:
  - perf_hazard increments on each cycle with hazard & ~branch_PC_contral & ~mem_stall.
  - perf_flush increments on each cycle with nop_ID.
  - perf_memstall increments on each mem_stall cycle.
- Watchdog:
  - Counts consecutive mem_stall cycles and clears when mem_stall = 0.
  - mem_timeout sets on the cycle the count reaches TIMEOUT.
  - mem_timeout clears only on reset.
- Reset mid-stall or mid-hazard: all state clears the next edge, and outputs reflect an empty scoreboard.
- Writes to x0 are never tracked.
- Same-cycle write in WB and read in ID relies on register-file write-through. Entries beyond DEPTH-1 are not checked.

Test Plan:
- FWD_EN=1: issue add x5, then add x6,x5,x5 → second in ID sees fwd_sel_rs1 = fwd_sel_rs2 = 1, no stall, perf_hazard = 0.
- FWD_EN=1, LOAD_LAT=1: lw x5, then add x6,x5,x0 → 1 cycle stall_ID=1, nop_EX=1; next cycle fwd_sel_rs1 = 2, stall 0; perf_hazard = 1.
- FWD_EN=0, DEPTH=3: add x5, then use x5 → stall_ID high exactly 3 cycles, fwd_sel = 0 throughout.
- Writes to x3 in entries 0 and 1, reader of x3 → fwd_sel_rs1 = 1 (youngest). Writer of x0 then reader of x0 → fwd_sel = 0, no hazard.
- branch_PC_contral=1 coincident with a load-use hazard → nop_ID = nop_EX = 1, stall_ID = 0, perf_flush = 1, perf_hazard unchanged.
- TIMEOUT=16, iready_n held 20 cycles → all stall_* = 1, scoreboard frozen, nop_* = 0. mem_timeout rises after the 16th cycle and stays high after iready_n drops. perf_memstall = 20. rst low one cycle clears everything.
